leaky_relu_deriv_parent: RTL and testbench

Two-column backward-pass unit for the leaky-ReLU activation stage. During the forward pass it caches each column's pre-activation values (H) in order in a small per-column FIFO. During the backward pass it multiplies each incoming gradient by the leaky-ReLU derivative of the matching cached H, giving dL/dH. It sits between the systolic array's backward-gradient outputs and the unified buffer, mirroring the forward leaky-ReLU stage column for column.

---
 rtl/leaky_relu_deriv_pkg.sv | 35 +++
 rtl/leaky_relu_deriv_child.sv | 100 ++++++++++
 rtl/leaky_relu_deriv_parent.sv | 64 ++++++
 tb/tb_leaky_relu_deriv_parent.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/leaky_relu_deriv_pkg.sv
// Shared Q8.8 fixed-point constants and the saturating multiply used by the
// forward and backward leaky-ReLU stages.
package leaky_relu_deriv_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

  localparam logic signed [2*DATA_W-1:0] SAT_MAX_W = 32'sh0000_7FFF;
  localparam logic signed [2*DATA_W-1:0] SAT_MIN_W = 32'shFFFF_8000;

  // Full-width product, arithmetic (floor) shift, then clamp to the Q8.8 range.
  function automatic logic signed [DATA_W-1:0] fx_sat_mul(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input int unsigned              frac
  );
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] shifted;
    logic signed [DATA_W-1:0]   res;
    prod    = a * b;
    shifted = prod >>> frac;
    if (shifted > SAT_MAX_W) begin
      res = SAT_MAX;
    end else if (shifted < SAT_MIN_W) begin
      res = SAT_MIN;
    end else begin
      res = shifted[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/leaky_relu_deriv_child.sv
// One column of the leaky-ReLU backward unit: H cache FIFO, derivative
// multiply, registered output and sticky underflow/overflow flags.
module leaky_relu_deriv_child
  import leaky_relu_deriv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FRAC  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] leak_factor,
  input  logic                     h_valid,
  input  logic signed [DATA_W-1:0] h_data,
  input  logic                     grad_valid,
  input  logic signed [DATA_W-1:0] grad_data,
  output logic signed [DATA_W-1:0] deriv_data,
  output logic                     deriv_valid,
  output logic                     underflow,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic signed [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic signed [DATA_W-1:0] data_r;
  logic                     valid_r;
  logic                     underflow_r;
  logic                     overflow_r;

  logic                     empty_s;
  logic                     full_s;
  logic                     pop_ok_s;
  logic                     push_ok_s;
  logic signed [DATA_W-1:0] head_s;
  logic signed [DATA_W-1:0] deriv_s;

  // Push/pop qualification; a full cache still accepts a push when it pops.
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    full_s    = (count_r == CNT_W'(DEPTH));
    pop_ok_s  = grad_valid & ~empty_s;
    push_ok_s = h_valid & (~full_s | pop_ok_s);
    head_s    = mem_r[rd_ptr_r];
    if (head_s[DATA_W-1] == 1'b0) begin
      deriv_s = grad_data;
    end else begin
      deriv_s = fx_sat_mul(grad_data, leak_factor, FRAC);
    end
  end

  // Cache storage; contents are don't-care once the count is cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      mem_r[wr_ptr_r] <= h_data;
    end
  end

  // Pointers, occupancy, output register and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      valid_r     <= 1'b0;
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        data_r   <= deriv_s;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      valid_r <= pop_ok_s;
      if (grad_valid && empty_s) begin
        underflow_r <= 1'b1;
      end
      if (h_valid && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign deriv_data  = data_r;
  assign deriv_valid = valid_r;
  assign underflow   = underflow_r;
  assign overflow    = overflow_r;

endmodule

// File: rtl/leaky_relu_deriv_parent.sv
// Two-column leaky-ReLU backward unit: one independent child per column,
// sharing the leak factor and packing the sticky error bits.
module leaky_relu_deriv_parent
  import leaky_relu_deriv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FRAC  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] lr_leak_factor_in,
  input  logic                     lr_h_valid_1_in,
  input  logic                     lr_h_valid_2_in,
  input  logic signed [DATA_W-1:0] lr_h_data_1_in,
  input  logic signed [DATA_W-1:0] lr_h_data_2_in,
  input  logic                     lr_valid_1_in,
  input  logic                     lr_valid_2_in,
  input  logic signed [DATA_W-1:0] lr_data_1_in,
  input  logic signed [DATA_W-1:0] lr_data_2_in,
  output logic signed [DATA_W-1:0] lr_data_1_out,
  output logic signed [DATA_W-1:0] lr_data_2_out,
  output logic                     lr_valid_1_out,
  output logic                     lr_valid_2_out,
  output logic [1:0]               lr_underflow_out,
  output logic [1:0]               lr_overflow_out
);

  logic underflow_1_s;
  logic underflow_2_s;
  logic overflow_1_s;
  logic overflow_2_s;

  leaky_relu_deriv_child #(.DEPTH(DEPTH), .FRAC(FRAC)) u_col1 (
    .clk         (clk),
    .rst         (rst),
    .leak_factor (lr_leak_factor_in),
    .h_valid     (lr_h_valid_1_in),
    .h_data      (lr_h_data_1_in),
    .grad_valid  (lr_valid_1_in),
    .grad_data   (lr_data_1_in),
    .deriv_data  (lr_data_1_out),
    .deriv_valid (lr_valid_1_out),
    .underflow   (underflow_1_s),
    .overflow    (overflow_1_s)
  );

  leaky_relu_deriv_child #(.DEPTH(DEPTH), .FRAC(FRAC)) u_col2 (
    .clk         (clk),
    .rst         (rst),
    .leak_factor (lr_leak_factor_in),
    .h_valid     (lr_h_valid_2_in),
    .h_data      (lr_h_data_2_in),
    .grad_valid  (lr_valid_2_in),
    .grad_data   (lr_data_2_in),
    .deriv_data  (lr_data_2_out),
    .deriv_valid (lr_valid_2_out),
    .underflow   (underflow_2_s),
    .overflow    (overflow_2_s)
  );

  assign lr_underflow_out = {underflow_2_s, underflow_1_s};
  assign lr_overflow_out  = {overflow_2_s, overflow_1_s};

endmodule

// File: tb/tb_leaky_relu_deriv_parent.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per column,
// a negedge monitor pops and compares whenever an output valid is seen.
module tb_leaky_relu_deriv_parent;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] lr_leak_factor_in;
  logic               lr_h_valid_1_in, lr_h_valid_2_in;
  logic signed [15:0] lr_h_data_1_in, lr_h_data_2_in;
  logic               lr_valid_1_in, lr_valid_2_in;
  logic signed [15:0] lr_data_1_in, lr_data_2_in;
  logic signed [15:0] lr_data_1_out, lr_data_2_out;
  logic               lr_valid_1_out, lr_valid_2_out;
  logic [1:0]         lr_underflow_out, lr_overflow_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  logic [15:0] ov_h [9];
  logic [15:0] ov_g [8];
  logic [15:0] ov_e [8];

  always #5 clk = ~clk;

  leaky_relu_deriv_parent #(.DEPTH(8), .FRAC(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .lr_leak_factor_in (lr_leak_factor_in),
    .lr_h_valid_1_in   (lr_h_valid_1_in),
    .lr_h_valid_2_in   (lr_h_valid_2_in),
    .lr_h_data_1_in    (lr_h_data_1_in),
    .lr_h_data_2_in    (lr_h_data_2_in),
    .lr_valid_1_in     (lr_valid_1_in),
    .lr_valid_2_in     (lr_valid_2_in),
    .lr_data_1_in      (lr_data_1_in),
    .lr_data_2_in      (lr_data_2_in),
    .lr_data_1_out     (lr_data_1_out),
    .lr_data_2_out     (lr_data_2_out),
    .lr_valid_1_out    (lr_valid_1_out),
    .lr_valid_2_out    (lr_valid_2_out),
    .lr_underflow_out  (lr_underflow_out),
    .lr_overflow_out   (lr_overflow_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every valid output must match the head of its column's queue.
  always @(negedge clk) begin
    if (lr_valid_1_out === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL col1_unexpected_valid actual=%h expected=no_output", lr_data_1_out);
      end else begin
        check("col1_data", {16'h0, lr_data_1_out}, {16'h0, q1.pop_front()});
      end
    end
    if (lr_valid_2_out === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL col2_unexpected_valid actual=%h expected=no_output", lr_data_2_out);
      end else begin
        check("col2_data", {16'h0, lr_data_2_out}, {16'h0, q2.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input logic ex1, input logic [15:0] e1, input logic ex2, input logic [15:0] e2);
    if (ex1) q1.push_back(e1);
    if (ex2) q2.push_back(e2);
    @(posedge clk); #1;
    lr_h_valid_1_in = 1'b0; lr_h_valid_2_in = 1'b0;
    lr_valid_1_in   = 1'b0; lr_valid_2_in   = 1'b0;
  endtask

  task automatic push1(input logic [15:0] h);
    lr_h_valid_1_in = 1'b1; lr_h_data_1_in = h; tick(1'b0, 16'h0, 1'b0, 16'h0);
  endtask
  task automatic push2(input logic [15:0] h);
    lr_h_valid_2_in = 1'b1; lr_h_data_2_in = h; tick(1'b0, 16'h0, 1'b0, 16'h0);
  endtask
  task automatic grad1(input logic [15:0] g, input logic ex, input logic [15:0] e);
    lr_valid_1_in = 1'b1; lr_data_1_in = g; tick(ex, e, 1'b0, 16'h0);
  endtask
  task automatic grad2(input logic [15:0] g, input logic ex, input logic [15:0] e);
    lr_valid_2_in = 1'b1; lr_data_2_in = g; tick(1'b0, 16'h0, ex, e);
  endtask

  task automatic drain(input string tag);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_q1_drained"}, q1.size(), 0);
    check({tag, "_q2_drained"}, q2.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data1"}, {16'h0, lr_data_1_out}, 32'h0);
    check({tag, "_data2"}, {16'h0, lr_data_2_out}, 32'h0);
    check({tag, "_valid"}, {30'h0, lr_valid_2_out, lr_valid_1_out}, 32'h0);
    check({tag, "_flags"}, {28'h0, lr_overflow_out, lr_underflow_out}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    ov_h = '{16'h0001, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0003, 16'hFFFD, 16'h0004, 16'hFFFC, 16'h0005};
    ov_g = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0070, 16'h0080};
    ov_e = '{16'h0010, 16'h0010, 16'h0030, 16'h0020, 16'h0050, 16'h0030, 16'h0070, 16'h0040};

    rst = 1'b1;
    lr_leak_factor_in = 16'h0019;
    lr_h_valid_1_in = 1'b0; lr_h_valid_2_in = 1'b0;
    lr_h_data_1_in  = 16'h0; lr_h_data_2_in = 16'h0;
    lr_valid_1_in   = 1'b0; lr_valid_2_in   = 1'b0;
    lr_data_1_in    = 16'h0; lr_data_2_in    = 16'h0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check_reset_state("por");

    // Unit path, leaky path, and H == 0 on the unit path
    lr_leak_factor_in = 16'h0019;
    push1(16'h0100); grad1(16'h0200, 1'b1, 16'h0200);
    push1(16'hFF00); grad1(16'h0200, 1'b1, 16'h0032);
    push1(16'h0000); grad1(16'hFE00, 1'b1, 16'hFE00);
    push1(16'hFFFF); grad1(16'h0100, 1'b1, 16'h0019);
    push1(16'hFFFF); grad1(16'hFFFF, 1'b1, 16'hFFFF);

    // Saturation at both bounds
    lr_leak_factor_in = 16'h7FFF;
    push1(16'h8000); grad1(16'h7FFF, 1'b1, 16'h7FFF);
    lr_leak_factor_in = 16'h0200;
    push1(16'hFFFF); grad1(16'h8000, 1'b1, 16'h8000);
    drain("basic");

    // Gradient on an empty cache
    grad1(16'h0100, 1'b0, 16'h0);
    check("underflow_col1", {30'h0, lr_underflow_out}, 32'h1);
    check("no_overflow_yet", {30'h0, lr_overflow_out}, 32'h0);

    // Column 2: DEPTH+1 pushes, then DEPTH ordered pops, then one more pop
    lr_leak_factor_in = 16'h0080;
    for (int i = 0; i < 9; i++) push2(ov_h[i]);
    check("overflow_col2", {30'h0, lr_overflow_out}, 32'h2);
    for (int i = 0; i < 8; i++) grad2(ov_g[i], 1'b1, ov_e[i]);
    grad2(16'h0100, 1'b0, 16'h0);
    check("underflow_both", {30'h0, lr_underflow_out}, 32'h3);
    drain("fifo");

    // Full cache with simultaneous push and pop: no overflow
    do_reset();
    check_reset_state("rst1");
    for (int i = 0; i < 8; i++) push2(16'h0100);
    lr_h_valid_2_in = 1'b1; lr_h_data_2_in = 16'hFF00;
    grad2(16'h0100, 1'b1, 16'h0100);
    check("full_pushpop_no_ovf", {30'h0, lr_overflow_out}, 32'h0);
    for (int i = 0; i < 7; i++) grad2(16'h0100, 1'b1, 16'h0100);
    grad2(16'h0100, 1'b1, 16'h0080);
    check("full_flags_clean", {28'h0, lr_overflow_out, lr_underflow_out}, 32'h0);
    drain("full");

    // Empty cache, push and gradient together: underflow, H still stored
    lr_h_valid_1_in = 1'b1; lr_h_data_1_in = 16'hFF00;
    grad1(16'h0100, 1'b0, 16'h0);
    check("same_cycle_underflow", {30'h0, lr_underflow_out}, 32'h1);
    grad1(16'h0100, 1'b1, 16'h0080);

    // Interleaved traffic on both columns
    do_reset();
    lr_h_valid_1_in = 1'b1; lr_h_data_1_in = 16'h0100;
    lr_h_valid_2_in = 1'b1; lr_h_data_2_in = 16'hFF00;
    tick(1'b0, 16'h0, 1'b0, 16'h0);
    lr_h_valid_1_in = 1'b1; lr_h_data_1_in = 16'hFF00;
    lr_h_valid_2_in = 1'b1; lr_h_data_2_in = 16'h0200;
    lr_valid_1_in = 1'b1; lr_data_1_in = 16'h0100;
    lr_valid_2_in = 1'b1; lr_data_2_in = 16'h0100;
    tick(1'b1, 16'h0100, 1'b1, 16'h0080);
    lr_h_valid_1_in = 1'b1; lr_h_data_1_in = 16'hFE00;
    lr_h_valid_2_in = 1'b1; lr_h_data_2_in = 16'h0000;
    lr_valid_1_in = 1'b1; lr_data_1_in = 16'h0100;
    lr_valid_2_in = 1'b1; lr_data_2_in = 16'h0100;
    tick(1'b1, 16'h0080, 1'b1, 16'h0100);
    lr_valid_1_in = 1'b1; lr_data_1_in = 16'h0100;
    lr_valid_2_in = 1'b1; lr_data_2_in = 16'h0100;
    tick(1'b1, 16'h0080, 1'b1, 16'h0100);
    check("interleave_flags", {28'h0, lr_overflow_out, lr_underflow_out}, 32'h0);
    drain("interleave");

    // Mid-stream reset with 3 entries cached and a gradient in the reset cycle
    push1(16'h0100); push1(16'h0200); push1(16'h0300);
    rst = 1'b1;
    lr_valid_1_in = 1'b1; lr_data_1_in = 16'h0100;
    tick(1'b0, 16'h0, 1'b0, 16'h0);
    rst = 1'b0;
    check_reset_state("rst_mid");
    grad1(16'h0100, 1'b0, 16'h0);
    check("post_reset_underflow", {30'h0, lr_underflow_out}, 32'h1);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
